gray_conv_arbiter: RTL and testbench
====================================

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter width, default 3: bit width of binary operands and Gray results (legal range 1..16).
REQ-002 Parameter nreq, default 4: number of requesters (legal range 2..8).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port req_valid  input  nreq  per-requester request valid.
REQ-007 Port req_bin  input  nreq x width  per-requester binary operand.
REQ-008 Port req_ready  output  nreq  per-requester accept strobe, at most one bit high.
REQ-009 Port rsp_valid  output  1  response valid.
REQ-010 Port rsp_ready  input  1  response consumer ready.
REQ-011 Port rsp_gray  output  width  Gray code of the accepted operand.
REQ-012 Port rsp_id  output  max(1,$clog2(nreq))  index of the served requester.
REQ-013 Port conv_count  output  16  number of completed responses, saturating.
REQ-014 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM SHALL have two states: IDLE and RESP.
REQ-016 In IDLE with any req_valid high, req_ready SHALL be asserted combinationally for exactly one requester: the first valid index found scanning upward, with wrap-around, from (last_grant+1) mod nreq.
REQ-017 A request SHALL be accepted on a rising edge when req_valid[i] and req_ready[i] are both high.
REQ-018 On accept, the block SHALL register req_bin[i] and i, move to RESP, and update last_grant to i.
REQ-019 rsp_valid SHALL rise on the cycle after accept, a latency of 1 cycle.
REQ-020 rsp_gray SHALL equal b XOR (b >> 1) of the registered operand b; MSB SHALL be passed through unchanged.
REQ-021 In RESP, req_ready SHALL be all-zero, and rsp_valid, rsp_gray and rsp_id SHALL hold stable until rsp_ready is high.
REQ-022 On rsp_valid and rsp_ready high at a rising edge, the FSM SHALL return to IDLE and conv_count SHALL increment unless already 16'hFFFF.
REQ-023 Peak throughput SHALL be one response per 2 cycles.
REQ-024 Requesters SHALL hold req_valid and req_bin until accepted; a req_valid drop before accept is legal and SHALL simply remove that requester from arbitration.
REQ-025 With no req_valid high, IDLE SHALL persist and last_grant SHALL be unchanged.
REQ-026 conv_count SHALL saturate at 16'hFFFF with no wrap.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_gray 0, rsp_id 0, conv_count 0, busy 0, and last_grant nreq-1, so that index 0 has first priority.
REQ-028 A reset during RESP SHALL discard the pending response without incrementing conv_count.
REQ-029 req_ready SHALL be all-zero while rst_n is low.

Structure
REQ-030 A shared package gray_pkg SHALL hold the FSM state enum and the default width and nreq constants.
REQ-031 Conversion SHALL be done by instantiating the existing combinational bin-to-Gray module gray_converter (parameter width) on the registered operand; no other sub-module is used.
REQ-032 The round-robin pointer and FSM SHALL be in this module; all outputs except req_ready SHALL be registered.

Verification
REQ-033 Single requester: req_valid=4'b0001, req_bin[0]=3'b101, rsp_ready=1 -> req_ready[0]=1 in cycle 0; rsp_valid=1, rsp_gray=3'b111, rsp_id=0 in cycle 1; conv_count=1.
REQ-034 All four valid from reset, operands 0,1,2,3, rsp_ready=1 -> grants in order 0,1,2,3; rsp_gray sequence 000,001,011,010; responses every 2 cycles.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0, busy=1; rsp_ready=1 -> one handshake, then return to IDLE.
REQ-036 Reset mid-RESP: rst_n=0 while rsp_valid=1 -> rsp_valid=0 asynchronously, conv_count unchanged at 0; after release, requester 0 has priority.
REQ-037 Saturation: force 65535 completions, or preload by a bench hook -> conv_count stays 16'hFFFF on the next handshake.
REQ-038 Exhaustive: every req_bin 0..7 on every requester -> rsp_gray matches b^(b>>1) for all 32 cases.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-conversion arbiter.
//   state_t       : arbiter FSM state encoding
//   default_width : default operand / Gray result width
//   default_nreq  : default number of requesters
//   count_w       : width of the completed-response counter
package gray_pkg;

  localparam int unsigned default_width = 3;
  localparam int unsigned default_nreq  = 4;
  localparam int unsigned count_w       = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/gray_converter.sv
// Combinational binary-to-Gray converter.
//   bin    : binary operand
//   gray_c : Gray code of bin (MSB passes through unchanged)
module gray_converter #(
  parameter int unsigned width = 3
) (
  input  logic [width-1:0] bin,
  output logic [width-1:0] gray_c
);

  // Shifting in a zero leaves the MSB untouched by the XOR.
  assign gray_c = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that accepts one binary operand at a time from nreq
// requesters and returns its Gray code with the index of the served requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_bin    : per-requester binary operand
//   req_ready  : per-requester accept strobe (combinational, one-hot or zero)
//   rsp_valid  : response valid, held until rsp_ready
//   rsp_ready  : response consumer ready
//   rsp_gray   : Gray code of the accepted operand
//   rsp_id     : index of the served requester
//   conv_count : saturating count of completed responses
//   busy       : high while a response is pending
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter  int unsigned width = default_width,
  parameter  int unsigned nreq  = default_nreq,
  localparam int unsigned idw   = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [nreq-1:0]             req_valid,
  input  logic [nreq-1:0][width-1:0]  req_bin,
  output logic [nreq-1:0]             req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [width-1:0]            rsp_gray,
  output logic [idw-1:0]              rsp_id,
  output logic [count_w-1:0]          conv_count,
  output logic                        busy
);

  localparam logic [count_w-1:0] count_max = '1;

  state_t           state_q;
  state_t           state_d;
  logic [idw-1:0]   last_grant_q;
  logic [width-1:0] operand_q;
  logic [idw-1:0]   cand_c;
  logic [idw-1:0]   grant_idx_c;
  logic             grant_found_c;
  logic             accept_c;
  logic             handshake_c;

  // Round-robin pick: first valid index scanning up from last_grant+1 with wrap.
  always_comb begin
    cand_c        = '0;
    grant_idx_c   = '0;
    grant_found_c = 1'b0;
    for (int unsigned k = 1; k <= nreq; k++) begin
      cand_c = idw'((32'(last_grant_q) + k) % nreq);
      if (!grant_found_c && req_valid[cand_c]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
  end

  // Next-state and strobe decode; req_ready is gated by rst_n so it stays low in reset.
  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    accept_c    = 1'b0;
    handshake_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && grant_found_c) begin
          req_ready[grant_idx_c] = 1'b1;
          accept_c               = 1'b1;
          state_d                = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          handshake_c = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured request, response flags, pointer and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= idw'(nreq - 1);
      operand_q    <= '0;
      rsp_id       <= '0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
      conv_count   <= '0;
    end else begin
      if (accept_c) begin
        operand_q    <= req_bin[grant_idx_c];
        rsp_id       <= grant_idx_c;
        last_grant_q <= grant_idx_c;
        rsp_valid    <= 1'b1;
        busy         <= 1'b1;
      end
      if (handshake_c) begin
        rsp_valid <= 1'b0;
        busy      <= 1'b0;
        if (conv_count != count_max) begin
          conv_count <= conv_count + count_w'(1);
        end
      end
    end
  end

  // Gray result derived from the captured operand only, so it is stable in RESP.
  gray_converter #(
    .width (width)
  ) u_gray_converter (
    .bin    (operand_q),
    .gray_c (rsp_gray)
  );

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter (width=3, nreq=4).
module tb_gray_conv_arbiter;

  localparam int unsigned width = 3;
  localparam int unsigned nreq  = 4;
  localparam int unsigned idw   = 2;

  typedef struct packed {
    logic [idw-1:0]   id;
    logic [width-1:0] gray;
  } exp_t;

  logic                       clk;
  logic                       rst_n;
  logic [nreq-1:0]            req_valid;
  logic [nreq-1:0][width-1:0] req_bin;
  logic [nreq-1:0]            req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [width-1:0]           rsp_gray;
  logic [idw-1:0]             rsp_id;
  logic [15:0]                conv_count;
  logic                       busy;

  exp_t sb[$];
  int   checks;
  int   errors;

  gray_conv_arbiter #(
    .width (width),
    .nreq  (nreq)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_bin    (req_bin),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_gray   (rsp_gray),
    .rsp_id     (rsp_id),
    .conv_count (conv_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [width-1:0] gray_of(input logic [width-1:0] b);
    logic [width-1:0] g;
    g[width-1] = b[width-1];
    for (int j = 0; j < int'(width) - 1; j++) g[j] = b[j] ^ b[j+1];
    return g;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_gray !== 3'b000 || rsp_id !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b gray=%b id=%0d busy=%b, want 0 000 0 0", rsp_valid, rsp_gray, rsp_id, busy);
    end
    checks++;
    if (conv_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", conv_count);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_priority: got %b want 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t e;
    req_bin[0] = 3'b101;
    req_valid  = 4'b0001;
    rsp_ready  = 1'b1;
    sb.push_back('{id: 2'd0, gray: 3'b111});
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_gray !== e.gray || rsp_id !== e.id || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp: valid=%b gray=%b id=%0d busy=%b, want 1 %b %0d 1", rsp_valid, rsp_gray, rsp_id, busy, e.gray, e.id);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || conv_count !== 16'd1) begin
      errors++;
      $display("FAIL single_done: valid=%b busy=%b count=%0d, want 0 0 1", rsp_valid, busy, conv_count);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [width-1:0] rr_gray [4];
    rr_gray = '{3'b000, 3'b001, 3'b011, 3'b010};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_bin[i] = 3'(i);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{id: 2'(i), gray: rr_gray[i]});
      #1;
      checks++;
      if (req_ready !== 4'(1 << i)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 4'(1 << i));
      end
      @(negedge clk);
      req_valid[i] = 1'b0;
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_gray !== e.gray || rsp_id !== e.id) begin
        errors++;
        $display("FAIL rr_rsp%0d: valid=%b gray=%b id=%0d, want 1 %b %0d", i, rsp_valid, rsp_gray, rsp_id, e.gray, e.id);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: rsp_valid got %b want 0", i, rsp_valid);
      end
    end
    checks++;
    if (conv_count !== 16'd4) begin
      errors++;
      $display("FAIL rr_count: got %0d want 4", conv_count);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    req_bin[2] = 3'b110;
    req_valid  = 4'b0100;
    rsp_ready  = 1'b0;
    sb.push_back('{id: 2'd2, gray: 3'b101});
    @(negedge clk);
    req_valid = 4'b1111;
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_gray !== e.gray || rsp_id !== e.id || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b gray=%b id=%0d ready=%b busy=%b, want 1 %b %0d 0000 1", k, rsp_valid, rsp_gray, rsp_id, req_ready, busy, e.gray, e.id);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || conv_count !== 16'd5) begin
      errors++;
      $display("FAIL bp_release: valid=%b busy=%b count=%0d, want 0 0 5", rsp_valid, busy, conv_count);
    end
    @(negedge clk);
    checks++;
    if (conv_count !== 16'd5 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single_hs: count=%0d valid=%b, want 5 0", conv_count, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_resp();
    exp_t e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_bin[2] = 3'b100;
    req_valid  = 4'b0100;
    rsp_ready  = 1'b0;
    sb.push_back('{id: 2'd2, gray: 3'b110});
    @(negedge clk);
    req_valid = 4'b1111;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_gray !== e.gray || rsp_id !== e.id) begin
      errors++;
      $display("FAIL mid_pre: valid=%b gray=%b id=%0d, want 1 %b %0d", rsp_valid, rsp_gray, rsp_id, e.gray, e.id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async: valid=%b busy=%b id=%0d ready=%b, want 0 0 0 0000", rsp_valid, busy, rsp_id, req_ready);
    end
    checks++;
    if (conv_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_count: got %0d want 0", conv_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_priority: got %b want 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    exp_t e;
    req_bin[1] = 3'b011;
    req_valid  = 4'b0010;
    rsp_ready  = 1'b0;
    sb.push_back('{id: 2'd1, gray: 3'b010});
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_gray !== e.gray || rsp_id !== e.id) begin
      errors++;
      $display("FAIL sat_rsp1: valid=%b gray=%b id=%0d, want 1 %b %0d", rsp_valid, rsp_gray, rsp_id, e.gray, e.id);
    end
    force dut.conv_count = 16'hFFFE;
    #1;
    release dut.conv_count;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (conv_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h want ffff", conv_count);
    end
    req_bin[3] = 3'b111;
    req_valid  = 4'b1000;
    sb.push_back('{id: 2'd3, gray: 3'b100});
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_gray !== e.gray || rsp_id !== e.id) begin
      errors++;
      $display("FAIL sat_rsp2: valid=%b gray=%b id=%0d, want 1 %b %0d", rsp_valid, rsp_gray, rsp_id, e.gray, e.id);
    end
    @(negedge clk);
    checks++;
    if (conv_count !== 16'hFFFF || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold: count=%h valid=%b, want ffff 0", conv_count, rsp_valid);
    end
  endtask

  task automatic test_exhaustive();
    exp_t e;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 8; b++) begin
        req_bin[i] = 3'(b);
        req_valid  = 4'(1 << i);
        sb.push_back('{id: 2'(i), gray: gray_of(3'(b))});
        #1;
        checks++;
        if (req_ready !== 4'(1 << i)) begin
          errors++;
          $display("FAIL exh_ready r%0d b%0d: got %b want %b", i, b, req_ready, 4'(1 << i));
        end
        @(negedge clk);
        req_valid = '0;
        e = sb.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_gray !== e.gray || rsp_id !== e.id) begin
          errors++;
          $display("FAIL exh_rsp r%0d b%0d: valid=%b gray=%b id=%0d, want 1 %b %0d", i, b, rsp_valid, rsp_gray, rsp_id, e.gray, e.id);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_bin   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_resp();
    test_saturation();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
